// File: rtl/i2c_master_sequencer_pkg.sv
// Shared types for the I2C master byte-level sequencer.
//   i2c_cmd_e   : command opcodes sent to the bit-level SCL/SDA engine
//   seq_state_e : sequencer FSM states
//   RW_READ / RW_WRITE : encoding of the R/W bit appended to the address
package i2c_master_pkg;

  typedef enum logic [2:0] {
    CMD_START  = 3'd0,
    CMD_TXBYTE = 3'd1,
    CMD_RXBYTE = 3'd2,
    CMD_STOP   = 3'd3,
    CMD_RSTART = 3'd4
  } i2c_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_ADDR,
    S_DATA,
    S_STOP,
    S_FIN
  } seq_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_master_sequencer_if.sv
// Command handshake between the byte sequencer and the bit-level engine.
//   cmd_valid/cmd_op/cmd_byte/cmd_nack : command, held stable while valid
//   cmd_done : one-cycle completion pulse from the engine
//   ack_in   : slave ACK for a completed TXBYTE (valid with cmd_done)
//   rx_byte  : received byte for a completed RXBYTE (valid with cmd_done)
// Modports: master = sequencer side, slave = bit engine side.
interface i2c_master_sequencer_if;
  import i2c_master_pkg::*;

  logic       cmd_valid;
  i2c_cmd_e   cmd_op;
  logic [7:0] cmd_byte;
  logic       cmd_nack;
  logic       cmd_done;
  logic       ack_in;
  logic [7:0] rx_byte;

  modport master (
    output cmd_valid, cmd_op, cmd_byte, cmd_nack,
    input  cmd_done, ack_in, rx_byte
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_byte, cmd_nack,
    output cmd_done, ack_in, rx_byte
  );

endinterface

// File: rtl/i2c_master_sequencer.sv
// Byte-level transaction FSM of the I2C master. Sits between the APB
// register/FIFO front end and the bit-level engine and drives the external
// byte counter (load / decrement, consumes its zero / one flags).
//
// Ports:
//   clk, n_rst        : clock, asynchronous active-low reset
//   go, rw, slave_addr: transaction start pulse and its parameters
//   cnt_zero, cnt_one : byte counter flags
//   load_buffer, decrement : byte counter strobes
//   bus               : command handshake to the bit engine (master side)
//   tx_data, tx_empty, tx_pop : TX FIFO head / pop
//   rx_data, rx_push  : registered received byte / RX FIFO push
//   busy, done, nack_err : status
//   hold_bus          : only with I2C_RSTART_EN; skip STOP and issue a
//                       repeated START on the next transaction
//
// Optional feature macro: I2C_RSTART_EN.
module i2c_master_sequencer
  import i2c_master_pkg::*;
#(
  parameter int BITS = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       go,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic       cnt_zero,
  input  logic       cnt_one,
`ifdef I2C_RSTART_EN
  input  logic       hold_bus,
`endif
  output logic       load_buffer,
  output logic       decrement,
  i2c_master_sequencer_if.master bus,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_pop,
  output logic [7:0] rx_data,
  output logic       rx_push,
  output logic       busy,
  output logic       done,
  output logic       nack_err
);

  // BITS only sizes the external counter; reject a degenerate value here.
  if (BITS < 1) begin : g_bits_chk
    $error("i2c_master_sequencer: BITS must be at least 1");
  end

  seq_state_e state;
  logic       rw_q;
  logic [6:0] addr_q;
  logic       bus_held;
  logic       skip_stop;
  logic       cmd_fire;
  logic       settling;

`ifdef I2C_RSTART_EN
  assign skip_stop = hold_bus;
`else
  assign skip_stop = 1'b0;
`endif

  assign cmd_fire = bus.cmd_valid & bus.cmd_done;
  // One cycle after a byte completes the counter and FIFO head are still
  // updating; wait so cnt_one / tx_data are current before the next issue.
  assign settling = decrement | tx_pop;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      rw_q          <= RW_WRITE;
      addr_q        <= '0;
      bus_held      <= 1'b0;
      load_buffer   <= 1'b0;
      decrement     <= 1'b0;
      tx_pop        <= 1'b0;
      rx_push       <= 1'b0;
      rx_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      nack_err      <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_op    <= CMD_START;
      bus.cmd_byte  <= '0;
      bus.cmd_nack  <= 1'b0;
    end else begin
      load_buffer <= 1'b0;
      decrement   <= 1'b0;
      tx_pop      <= 1'b0;
      rx_push     <= 1'b0;
      done        <= 1'b0;

      case (state)
        S_IDLE: if (go) begin
          rw_q        <= rw;
          addr_q      <= slave_addr;
          nack_err    <= 1'b0;
          load_buffer <= 1'b1;
          busy        <= 1'b1;
          state       <= S_LOAD;
        end

        S_LOAD: begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_op    <= bus_held ? CMD_RSTART : CMD_START;
          bus.cmd_nack  <= 1'b0;
          state         <= S_START;
        end

        S_START: if (cmd_fire) begin
          bus_held     <= 1'b0;
          bus.cmd_op   <= CMD_TXBYTE;
          bus.cmd_byte <= {addr_q, rw_q};
          state        <= S_ADDR;
        end

        S_ADDR: if (cmd_fire) begin
          if (bus.ack_in) begin
            bus.cmd_valid <= 1'b0;
            state         <= S_DATA;
          end else begin
            nack_err      <= 1'b1;
            bus.cmd_op    <= CMD_STOP;
            state         <= S_STOP;
          end
        end

        S_DATA: begin
          if (cmd_fire) begin
            decrement     <= ~cnt_zero;
            bus.cmd_valid <= 1'b0;
            if (rw_q == RW_READ) begin
              rx_data <= bus.rx_byte;
              rx_push <= 1'b1;
            end else begin
              tx_pop  <= 1'b1;
            end
            if (rw_q == RW_WRITE && !bus.ack_in) begin
              // Data NACK always releases the bus.
              nack_err      <= 1'b1;
              bus.cmd_valid <= 1'b1;
              bus.cmd_op    <= CMD_STOP;
              bus.cmd_nack  <= 1'b0;
              state         <= S_STOP;
            end else if (cnt_one) begin
              if (skip_stop) begin
                bus_held <= 1'b1;
                state    <= S_FIN;
              end else begin
                bus.cmd_valid <= 1'b1;
                bus.cmd_op    <= CMD_STOP;
                bus.cmd_nack  <= 1'b0;
                state         <= S_STOP;
              end
            end
          end else if (!bus.cmd_valid && !settling) begin
            if (cnt_zero) begin
              if (skip_stop) begin
                bus_held <= 1'b1;
                state    <= S_FIN;
              end else begin
                bus.cmd_valid <= 1'b1;
                bus.cmd_op    <= CMD_STOP;
                bus.cmd_nack  <= 1'b0;
                state         <= S_STOP;
              end
            end else if (rw_q == RW_READ) begin
              bus.cmd_valid <= 1'b1;
              bus.cmd_op    <= CMD_RXBYTE;
              bus.cmd_nack  <= cnt_one;
            end else if (!tx_empty) begin
              bus.cmd_valid <= 1'b1;
              bus.cmd_op    <= CMD_TXBYTE;
              bus.cmd_byte  <= tx_data;
              bus.cmd_nack  <= 1'b0;
            end
          end
        end

        S_STOP: if (cmd_fire) begin
          bus.cmd_valid <= 1'b0;
          bus_held      <= 1'b0;
          state         <= S_FIN;
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer: models the byte counter, TX FIFO
// and a bit engine that completes every command after a fixed latency.
module tb_i2c_master_sequencer;
  import i2c_master_pkg::*;

  localparam int BITS = 6;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       go = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = '0;
  logic       cnt_zero, cnt_one;
  logic       load_buffer, decrement, tx_pop, rx_push, busy, done, nack_err;
  logic [7:0] tx_data, rx_data;
  logic       tx_empty;
`ifdef I2C_RSTART_EN
  logic       hold_bus = 1'b0;
`endif

  i2c_master_sequencer_if bus();

  always #5 clk = ~clk;

  i2c_master_sequencer #(.BITS(BITS)) dut (
    .clk(clk), .n_rst(n_rst), .go(go), .rw(rw), .slave_addr(slave_addr),
    .cnt_zero(cnt_zero), .cnt_one(cnt_one),
`ifdef I2C_RSTART_EN
    .hold_bus(hold_bus),
`endif
    .load_buffer(load_buffer), .decrement(decrement), .bus(bus),
    .tx_data(tx_data), .tx_empty(tx_empty), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_push(rx_push),
    .busy(busy), .done(done), .nack_err(nack_err)
  );

  // byte counter model: length 0 means 2^BITS bytes
  logic [BITS-1:0] pkt_len = '0;
  logic [BITS-1:0] cnt;
  logic            zf;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst)           begin cnt <= '0;        zf <= 1'b0; end
    else if (load_buffer) begin cnt <= pkt_len;   zf <= 1'b0; end
    else if (decrement)   begin cnt <= cnt - 1'b1; zf <= (int'(cnt) == 1); end
  assign cnt_zero = zf;
  assign cnt_one  = (int'(cnt) == 1) && !zf;

  // TX FIFO model
  logic [7:0] tx_mem [0:15];
  int tx_rd = 0;
  int tx_wr = 0;
  always @(posedge clk) if (tx_pop) tx_rd <= tx_rd + 1;
  assign tx_empty = (tx_rd == tx_wr);
  assign tx_data  = tx_mem[tx_rd[3:0]];

  task automatic tx_push(input logic [7:0] b);
    tx_mem[tx_wr[3:0]] = b;
    tx_wr++;
  endtask

  // bit engine model
  typedef struct packed {logic [2:0] op; logic [7:0] b; logic nack;} cmd_t;
  cmd_t       cmd_log[$];
  logic       addr_ack = 1'b1;
  logic [7:0] rx_vals [0:63];
  int         rx_idx = 0;
  int         eng_wait;
  logic [2:0] last_op;

  initial begin
    bus.cmd_done = 1'b0; bus.ack_in = 1'b0; bus.rx_byte = '0;
    eng_wait = 0; last_op = CMD_STOP;
    forever begin
      @(posedge clk); #1;
      if (!n_rst || bus.cmd_done || !bus.cmd_valid) begin
        bus.cmd_done = 1'b0;
        eng_wait = 0;
      end else if (eng_wait < 2) begin
        eng_wait++;
      end else begin
        eng_wait = 0;
        bus.cmd_done = 1'b1;
        cmd_log.push_back({bus.cmd_op, bus.cmd_byte, bus.cmd_nack});
        bus.ack_in = (bus.cmd_op == CMD_TXBYTE &&
                      (last_op == CMD_START || last_op == CMD_RSTART)) ? addr_ack : 1'b1;
        if (bus.cmd_op == CMD_RXBYTE) begin
          bus.rx_byte = rx_vals[rx_idx % 64];
          rx_idx++;
        end
        last_op = bus.cmd_op;
      end
    end
  end

  // output monitor
  int n_pop = 0, n_dec = 0, n_push = 0, n_done = 0, n_load = 0;
  logic [7:0] rx_log[$];
  always @(negedge clk) begin
    if (tx_pop)      n_pop  <= n_pop + 1;
    if (decrement)   n_dec  <= n_dec + 1;
    if (done)        n_done <= n_done + 1;
    if (load_buffer) n_load <= n_load + 1;
    if (rx_push) begin
      n_push <= n_push + 1;
      rx_log.push_back(rx_data);
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_cmd(input string tag, input int idx, input logic [2:0] op,
                         input logic [7:0] b, input logic nk, input bit use_b);
    cmd_t g;
    g = (idx < cmd_log.size()) ? cmd_log[idx] : '1;
    chk(tag, {g.op, use_b ? g.b : 8'h00, g.nack}, {op, use_b ? b : 8'h00, nk});
  endtask

  task automatic kick(input logic r, input logic [6:0] a, input int len);
    pkt_len = len[BITS-1:0];
    @(negedge clk);
    rw = r; slave_addr = a; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int d0, i;
    d0 = n_done; i = 0;
    while (n_done == d0 && i < max) begin @(negedge clk); i++; end
    chk({tag, " done"}, n_done - d0, 1);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, p0, d0, q0, r0, l0, n_rx, n_nk, nk_pos, bad;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset outs", {busy, bus.cmd_valid, bus.cmd_op, bus.cmd_byte, bus.cmd_nack,
                       load_buffer, decrement, tx_pop, rx_push, rx_data, done, nack_err}, 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // write 2 bytes to 0x50
    b = cmd_log.size(); p0 = n_pop; d0 = n_dec; l0 = n_load;
    tx_push(8'hA5); tx_push(8'h3C);
    kick(RW_WRITE, 7'h50, 2);
    wait_done("wr2", 500);
    chk("wr2 ncmd", cmd_log.size() - b, 5);
    chk_cmd("wr2 c0", b,   CMD_START,  8'h00, 1'b0, 0);
    chk_cmd("wr2 c1", b+1, CMD_TXBYTE, 8'hA0, 1'b0, 1);
    chk_cmd("wr2 c2", b+2, CMD_TXBYTE, 8'hA5, 1'b0, 1);
    chk_cmd("wr2 c3", b+3, CMD_TXBYTE, 8'h3C, 1'b0, 1);
    chk_cmd("wr2 c4", b+4, CMD_STOP,   8'h00, 1'b0, 0);
    chk("wr2 pops", n_pop - p0, 2);
    chk("wr2 decs", n_dec - d0, 2);
    chk("wr2 load", n_load - l0, 1);
    chk("wr2 stat", {busy, nack_err}, 0);

    // read 3 bytes from 0x51
    b = cmd_log.size(); d0 = n_dec; q0 = n_push; r0 = rx_log.size();
    for (int i = 0; i < 3; i++) rx_vals[(rx_idx + i) % 64] = 8'h11 * (i + 1);
    kick(RW_READ, 7'h51, 3);
    wait_done("rd3", 500);
    chk("rd3 ncmd", cmd_log.size() - b, 6);
    chk_cmd("rd3 c1", b+1, CMD_TXBYTE, 8'hA3, 1'b0, 1);
    chk_cmd("rd3 c2", b+2, CMD_RXBYTE, 8'h00, 1'b0, 0);
    chk_cmd("rd3 c3", b+3, CMD_RXBYTE, 8'h00, 1'b0, 0);
    chk_cmd("rd3 c4", b+4, CMD_RXBYTE, 8'h00, 1'b1, 0);
    chk_cmd("rd3 c5", b+5, CMD_STOP,   8'h00, 1'b0, 0);
    chk("rd3 push", n_push - q0, 3);
    chk("rd3 decs", n_dec - d0, 3);
    for (int i = 0; i < 3; i++)
      chk("rd3 data", (r0 + i < rx_log.size()) ? rx_log[r0 + i] : 8'hFF, 8'h11 * (i + 1));

    // address NACK
    b = cmd_log.size(); d0 = n_dec; p0 = n_pop;
    addr_ack = 1'b0;
    kick(RW_WRITE, 7'h20, 2);
    wait_done("nak", 500);
    chk("nak ncmd", cmd_log.size() - b, 3);
    chk_cmd("nak c1", b+1, CMD_TXBYTE, 8'h40, 1'b0, 1);
    chk_cmd("nak c2", b+2, CMD_STOP,   8'h00, 1'b0, 0);
    chk("nak err", nack_err, 1);
    chk("nak decs", n_dec - d0, 0);
    chk("nak pops", n_pop - p0, 0);
    addr_ack = 1'b1;
    b = cmd_log.size();
    rx_vals[rx_idx % 64] = 8'h5A;
    kick(RW_READ, 7'h51, 1);
    chk("nak clr", {busy, nack_err}, 2'b10);
    wait_done("rd1", 500);
    chk_cmd("rd1 c2", b+2, CMD_RXBYTE, 8'h00, 1'b1, 0);
    chk_cmd("rd1 c3", b+3, CMD_STOP,   8'h00, 1'b0, 0);

    // TX FIFO stall mid-packet
    b = cmd_log.size(); p0 = n_pop;
    tx_push(8'h01);
    kick(RW_WRITE, 7'h50, 3);
    for (int i = 0; i < 300 && n_pop == p0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cmd_valid || n_pop != p0 + 1) bad++;
    end
    chk("stall idle", bad, 0);
    tx_push(8'h02); tx_push(8'h03);
    wait_done("stall", 500);
    chk("stall ncmd", cmd_log.size() - b, 6);
    chk_cmd("stall c3", b+3, CMD_TXBYTE, 8'h02, 1'b0, 1);
    chk_cmd("stall c4", b+4, CMD_TXBYTE, 8'h03, 1'b0, 1);
    chk("stall pops", n_pop - p0, 3);

    // length 0 -> 2^BITS reads
    b = cmd_log.size(); q0 = n_push; r0 = rx_log.size();
    for (int i = 0; i < 64; i++) rx_vals[(rx_idx + i) % 64] = 8'(i);
    kick(RW_READ, 7'h51, 0);
    wait_done("len0", 3000);
    n_rx = 0; n_nk = 0; nk_pos = -1;
    for (int i = b; i < cmd_log.size(); i++)
      if (cmd_log[i].op == CMD_RXBYTE) begin
        if (cmd_log[i].nack) begin n_nk++; nk_pos = n_rx; end
        n_rx++;
      end
    chk("len0 nrx", n_rx, 64);
    chk("len0 nnack", n_nk, 1);
    chk("len0 nackpos", nk_pos, 63);
    chk("len0 push", n_push - q0, 64);
    chk("len0 last", (rx_log.size() > 0) ? rx_log[rx_log.size() - 1] : 8'hFF, 8'd63);

    // go while busy is ignored
    d0 = n_done; l0 = n_load;
    tx_push(8'h77);
    kick(RW_WRITE, 7'h50, 1);
    repeat (4) @(negedge clk);
    go = 1'b1; rw = 1'b1; @(negedge clk); go = 1'b0;
    wait_done("busygo", 500);
    repeat (30) @(negedge clk);
    chk("busygo dones", n_done - d0, 1);
    chk("busygo loads", n_load - l0, 1);

    // reset in DATA
    p0 = n_pop;
    tx_push(8'h81); tx_push(8'h82); tx_push(8'h83);
    kick(RW_WRITE, 7'h50, 3);
    for (int i = 0; i < 300 && n_pop == p0; i++) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("rst mid outs", {busy, bus.cmd_valid, bus.cmd_op, bus.cmd_byte, bus.cmd_nack,
                         load_buffer, decrement, tx_pop, rx_push, rx_data, done, nack_err}, 0);
    @(negedge clk);
    n_rst = 1'b1;
    tx_wr = tx_rd;
    d0 = n_done;
    repeat (20) @(negedge clk);
    chk("rst idle", {busy, bus.cmd_valid}, 0);
    chk("rst nodone", n_done - d0, 0);
    b = cmd_log.size();
    tx_push(8'h99);
    kick(RW_WRITE, 7'h50, 1);
    wait_done("post rst", 500);
    chk_cmd("post rst c0", b,   CMD_START,  8'h00, 1'b0, 0);
    chk_cmd("post rst c2", b+2, CMD_TXBYTE, 8'h99, 1'b0, 1);

`ifdef I2C_RSTART_EN
    b = cmd_log.size();
    tx_push(8'h44);
    hold_bus = 1'b1;
    kick(RW_WRITE, 7'h50, 1);
    wait_done("hold", 500);
    hold_bus = 1'b0;
    chk("hold ncmd", cmd_log.size() - b, 3);
    b = cmd_log.size();
    rx_vals[rx_idx % 64] = 8'h66;
    kick(RW_READ, 7'h51, 1);
    wait_done("rstart", 500);
    chk_cmd("rstart c0", b,   CMD_RSTART, 8'h00, 1'b0, 0);
    chk_cmd("rstart c3", b+3, CMD_STOP,   8'h00, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_master_sequencer.md
Name: i2c_master_sequencer

Overview:
- Byte-level transaction FSM of the I2C master.
- Sits between the APB register/FIFO front end and the bit-level SCL/SDA engine.
- Directly drives the byte counter: loads the packet length, decrements once per completed data byte, and consumes the counter's zero/one flags to choose the last-byte NACK and the STOP condition.

Parameters:
BITS, 6, width of packet_length; must equal the byte counter's BITS.

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
go  in  1  one-cycle pulse from the register block that starts a transaction; ignored while busy
rw  in  1  1 = read, 0 = write; sampled on go
slave_addr  in  7  7-bit slave address; sampled on go
cnt_zero  in  1  byte counter zero flag
cnt_one  in  1  byte counter one flag
load_buffer  out  1  counter load strobe
decrement  out  1  counter decrement strobe
cmd_valid  out  1  command to bit engine valid
cmd_op  out  3  0 START, 1 TXBYTE, 2 RXBYTE, 3 STOP, 4 RSTART
cmd_byte  out  8  byte to transmit (address or data)
cmd_nack  out  1  for RXBYTE: master drives NACK
cmd_done  in  1  one-cycle pulse: bit engine finished the current command
ack_in  in  1  slave ACK (1) or NACK (0) for the TXBYTE just completed; valid with cmd_done
tx_data  in  8  head of TX FIFO
tx_empty  in  1  TX FIFO empty
tx_pop  out  1  TX FIFO pop strobe
rx_byte  in  8  byte from the bit engine; valid with cmd_done on RXBYTE
rx_data  out  8  registered received byte
rx_push  out  1  RX FIFO push strobe
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of transaction
nack_err  out  1  sticky: slave NACKed; cleared by the next accepted go

Behaviour:
- Reset values: all outputs 0; state IDLE; rw and address registers cleared.
- States: IDLE, LOAD, START, ADDR, DATA, STOP, FIN.
- Command handshake: cmd_valid is held high in START, ADDR, DATA and STOP until the cycle cmd_done is seen. cmd_op, cmd_byte and cmd_nack are held stable while cmd_valid is high. cmd_done is ignored while cmd_valid is low.
- IDLE: on go, latch rw and slave_addr, clear nack_err, and assert load_buffer for one cycle. busy rises on the next cycle. Next state: LOAD.
- LOAD: one cycle so the counter register settles. Next state: START.
- START: cmd_op = START. On cmd_done, go to ADDR.
- ADDR: cmd_op = TXBYTE, cmd_byte = {slave_addr, rw}. On cmd_done:
  - ack_in = 1: go to DATA.
  - ack_in = 0: set nack_err and go to STOP.
- DATA, write (rw = 0):
  - While tx_empty = 1, cmd_valid stays low and the FSM stalls.
  - Otherwise cmd_op = TXBYTE and cmd_byte = tx_data.
  - On cmd_done: pulse tx_pop and decrement in the same cycle.
  - If ack_in = 0: set nack_err and go to STOP.
  - Else if cnt_one = 1 (this was the last byte): go to STOP.
  - Else: stay in DATA.
- DATA, read (rw = 1):
  - cmd_op = RXBYTE; cmd_nack = cnt_one.
  - On cmd_done: rx_data <= rx_byte, pulse rx_push on the next cycle, and pulse decrement.
  - If cnt_one = 1: go to STOP. Else: stay in DATA.
- STOP: cmd_op = STOP. On cmd_done, go to FIN.
- FIN: pulse done, drop busy, return to IDLE.
- Length rule: packet_length = 0 means 2^BITS bytes (counter behaviour). The sequencer never decrements when cnt_zero = 1. If cnt_zero = 1 on entry to DATA, it goes straight to STOP.
- go during busy is ignored. Simultaneous go and cmd_done in IDLE: cmd_done is ignored and go is accepted.
- Asynchronous reset mid-transaction returns to IDLE immediately with no STOP issued. Bus recovery is the bit engine's responsibility.

Optional Feature:
- Macro: I2C_RSTART_EN.
- With the macro: add input hold_bus. If hold_bus = 1 at the end of DATA, the STOP command is skipped; the FSM goes to FIN and keeps an internal bus_held flag. The next accepted go issues cmd_op = RSTART instead of START. bus_held clears after that RSTART, or after any STOP.
- Without the macro: no hold_bus port; every transaction ends with STOP and RSTART is never issued.

Decomposition:
- Package i2c_master_pkg:
  - enum i2c_cmd_e (START, TXBYTE, RXBYTE, STOP, RSTART, 3 bits).
  - enum seq_state_e.
  - localparams RW_READ = 1 and RW_WRITE = 0.
- No sub-module. The byte counter is instantiated alongside this block at the i2c_master level, not inside it.

Test Plan:
- Write, 2 bytes, addr 0x50, ACKs, TX FIFO holds 0xA5, 0x3C -> START; TXBYTE 0xA0; TXBYTE 0xA5; TXBYTE 0x3C; STOP; 2 tx_pop, 2 decrement, done pulse, nack_err = 0.
- Read, 3 bytes, addr 0x51, rx_byte 0x11, 0x22, 0x33 -> cmd_byte 0xA3; cmd_nack = 0, 0, 1; 3 rx_push with rx_data 0x11, 0x22, 0x33; then STOP.
- Address NACK (ack_in = 0 on ADDR) -> nack_err = 1, no decrement, STOP then done. Next go clears nack_err.
- Write with tx_empty = 1 for 10 cycles mid-packet -> cmd_valid low and no pop during the stall; resumes when the FIFO is non-empty.
- packet_length = 0, read, BITS = 6 -> exactly 64 RXBYTE commands, cmd_nack only on the 64th.
- Reset asserted during DATA; go pulsed while busy -> all outputs 0 and state IDLE after reset; the go during busy produces no second transaction.
